// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe register pipeline.
package dff_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 3;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int clog2_cnt(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid bit plus a data register with load enable,
// flush of the valid bit and synchronous reset to RESET_VAL.
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load_en,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;

  // Next-state: flush kills the beat, otherwise advance when downstream has room.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch inferred.
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_en) begin
      valid_d = valid_in;
      if (valid_in) data_d = data_in;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      valid_q <= 1'b0;
      // NOTE: the data register is reset too, so out_data is defined after reset.
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage valid/ready register pipeline with bubble collapsing,
// synchronous flush and an occupancy counter.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [clog2_cnt(DEPTH)-1:0]   count
);

  localparam int CNT_W = clog2_cnt(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             push, pop;
  logic [CNT_W-1:0] count_d, count_q;

  // Ready chain: a stage may load if it is empty or everything after it can move.
  always_comb begin
    logic chain;
    chain      = out_ready;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = chain || !valid[i];
      rdy[i] = chain;
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign pop       = out_valid && out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             s_valid_in;
    logic [WIDTH-1:0] s_data_in;

    if (i == 0) begin : g_head
      assign s_valid_in = push;
      assign s_data_in  = in_data;
    end else begin : g_body
      assign s_valid_in = valid[i-1];
      assign s_data_in  = data[i-1];
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load_en  (rdy[i]),
      .valid_in (s_valid_in),
      .data_in  (s_data_in),
      .valid_o  (valid[i]),
      .data_o   (data[i])
    );
  end

  // Occupancy: +1 on input transfer, -1 on output transfer; flush empties it.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed testbench for dff_pipe (WIDTH=8, DEPTH=3, RESET_VAL=0).
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int tests_run    = 0;
  int tests_failed = 0;

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 8'h00) begin tests_failed++; $display("FAIL reset_out_data got %h want 00", out_data); end
    tests_run++;
    if (count !== 2'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single_beat();
    logic [1:0] exp_cnt [4];
    logic       exp_ov  [4];
    exp_cnt = '{2'd1, 2'd1, 2'd1, 2'd0};
    exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    for (int k = 0; k < 4; k++) begin
      step();
      in_valid = 1'b0;
      tests_run++;
      if (count !== exp_cnt[k]) begin
        tests_failed++; $display("FAIL single_count[%0d] got %0d want %0d", k, count, exp_cnt[k]);
      end
      tests_run++;
      if (out_valid !== exp_ov[k]) begin
        tests_failed++; $display("FAIL single_out_valid[%0d] got %b want %b", k, out_valid, exp_ov[k]);
      end
      if (exp_ov[k]) begin
        tests_run++;
        if (out_data !== 8'hA5) begin tests_failed++; $display("FAIL single_out_data got %h want a5", out_data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_valid = (k < 10);
      in_data  = 8'(k + 1);
      #1;
      if (k < 10) begin
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready[%0d] got %b want 1", k, in_ready); end
      end
      step();
      if (k >= 2) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'(k - 1)) begin
          tests_failed++;
          $display("FAIL stream_out[%0d] got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 8'(k - 1));
        end
      end
    end
    in_valid = 1'b0;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      tests_failed++; $display("FAIL stream_drain got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_seq [3];
    exp_seq = '{8'h22, 8'h33, 8'h44};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    in_valid = 1'b0;
    step();
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h11 || count !== 2'd1) begin
      tests_failed++; $display("FAIL bp_collapse got v=%b d=%h cnt=%0d want v=1 d=11 cnt=1", out_valid, out_data, count);
    end
    // 22 and 33 squeeze into the empty stages behind 11.
    in_valid = 1'b1;
    in_data  = 8'h22;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_accept22 got %b want 1", in_ready); end
    step();
    in_data = 8'h33;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_accept33 got %b want 1", in_ready); end
    step();
    in_data = 8'h44;
    #1;
    tests_run++;
    if (in_ready !== 1'b0 || count !== 2'd3) begin
      tests_failed++; $display("FAIL bp_full got rdy=%b cnt=%0d want rdy=0 cnt=3", in_ready, count);
    end
    step();
    tests_run++;
    if (out_data !== 8'h11 || out_valid !== 1'b1 || count !== 2'd3) begin
      tests_failed++; $display("FAIL bp_hold got v=%b d=%h cnt=%0d want v=1 d=11 cnt=3", out_valid, out_data, count);
    end
    // Full with out_ready=1: push and pop in the same cycle.
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_full_pass got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[k]) begin
        tests_failed++; $display("FAIL bp_order[%0d] got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, exp_seq[k]);
      end
      if (k == 0) begin
        tests_run++;
        if (count !== 2'd3) begin tests_failed++; $display("FAIL bp_count_pushpop got %0d want 3", count); end
      end
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      tests_failed++; $display("FAIL bp_drain got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    step();
    in_data = 8'hBB;
    step();
    tests_run++;
    if (count !== 2'd2) begin tests_failed++; $display("FAIL flush_pre_count got %0d want 2", count); end
    flush   = 1'b1;
    in_data = 8'h77;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (count !== 2'd0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_clear got v=%b cnt=%0d want v=0 cnt=0", out_valid, count);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL flush_dropped[%0d] got v=%b d=%h want v=0", k, out_valid, out_data);
      end
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'hC1 + k);
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if (count !== 2'd3 || out_valid !== 1'b1 || out_data !== 8'hC1) begin
      tests_failed++; $display("FAIL midrst_full got v=%b d=%h cnt=%0d want v=1 d=c1 cnt=3", out_valid, out_data, count);
    end
    rst   = 1'b1;
    flush = 1'b1;
    step();
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== 2'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_clear got v=%b d=%h cnt=%0d rdy=%b want v=0 d=00 cnt=0 rdy=1",
               out_valid, out_data, count, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised successor to the single-bit positive-edge D flip-flop.
- A WIDTH-bit, DEPTH-stage register pipeline with a per-stage valid bit and valid/ready handshake on both sides.
- Empty stages collapse (bubble squeezing), and a synchronous flush is provided.
- Used as a generic retiming/delay element between datapath blocks that need backpressure.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 3, number of register stages (>=1).
- RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  pipeline accepts a beat this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds a valid beat.
- out_ready  input  1  downstream accepts a beat.
- out_data  output  WIDTH  last-stage data.
- count  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state changes on the rising edge of `clk`.
- Reset:
  - At the edge where rst=1: all valid[i]=0 and all data[i]=RESET_VAL.
  - Consequently out_valid=0, out_data=RESET_VAL, count=0.
  - in_ready=1 combinationally whenever rst=0 and flush=0.
- Stage numbering: 0 (input side) to DEPTH-1 (output side).
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready.
  - rdy[i] = !valid[i] || rdy[i+1].
  - in_ready = rdy[0] && !flush.
- Stage update, when rdy[i]=1:
  - Stage 0: valid[0] <= in_valid && in_ready; data[0] <= in_data if that beat is accepted.
  - Stage i>0: valid[i] <= valid[i-1]; data[i] <= data[i-1] if valid[i-1].
  - Data registers load only on an accepted beat; invalid stages otherwise hold their data.
  - When rdy[i]=0 the stage holds.
- Handshake rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - out_valid=valid[DEPTH-1] and out_data=data[DEPTH-1], both direct register outputs.
  - out_data/out_valid remain stable while out_valid && !out_ready.
- Latency and throughput:
  - Empty pipeline with out_ready=1: a beat accepted at edge N appears on out_valid after edge N+DEPTH-1, i.e. DEPTH cycles after it was presented.
  - Sustains one beat per cycle with out_ready=1.
- Bubble collapsing: with out_ready=0, valid beats advance into empty downstream stages. Capacity is DEPTH beats.
- Full: all valid and out_ready=0 -> in_ready=0.
- Full with out_ready=1: in_ready=1 in the same cycle, so simultaneous push and pop are allowed.
- count: registered; increments on input transfer only, decrements on output transfer only, unchanged when both or neither occur. Never exceeds DEPTH.
- Flush:
  - At the edge where flush=1 and rst=0: all valids clear, count=0. Data registers are untouched.
  - in_ready=0 during flush, so a concurrent input is dropped.
  - An output handshake in the flush cycle is still counted as delivered downstream.
- Priority: rst > flush > normal operation. Reset mid-stream discards all beats.

Decomposition:
- Package dff_pkg holds:
  - function clog2_cnt(depth) for the count width.
  - localparam DEFAULT_WIDTH=8, DEFAULT_DEPTH=3.
- Sub-module dff_pipe_stage: one valid bit plus a WIDTH-bit data register with load enable, flush and sync reset to RESET_VAL.
- dff_pipe instantiates DEPTH copies in a generate loop and builds the ready chain.

Test Plan:
- Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'h00; hold rst=1 for 2 cycles -> out_valid=0, out_data=8'h00, count=0, in_ready=1.
- Single beat: in_data=8'hA5 pulsed one cycle, out_ready=1 -> out_valid=1 with 8'hA5 exactly 3 cycles later for one cycle; count goes 1,1,1,0.
- Streaming: 8'h01..8'h0A back-to-back, out_ready=1 -> outputs in order on consecutive cycles starting 3 cycles after the first; in_ready never deasserts.
- Backpressure and collapse:
  - out_ready=0, one beat 8'h11 -> it reaches stage 2 after 3 cycles.
  - Push 8'h22, 8'h33, 8'h44 -> 8'h22 and 8'h33 accepted, 8'h44 stalls with in_ready=0, count=3.
  - Raise out_ready -> 8'h11 presented, 8'h44 accepted in the same cycle, order 11, 22, 33, 44.
- Flush: count=2, assert flush with in_valid=1, in_data=8'h77 -> next cycle count=0, out_valid=0; 8'h77 never appears.
- Reset mid-stream: pipeline full, assert rst together with flush -> next cycle all valids 0, out_data=RESET_VAL, count=0.
